clock_div_gen: RTL and testbench

CLOCK_DIV_GEN -- requirements
Module: clock_div_gen

---
 rtl/clock_div_gen_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 64 ++++++
 rtl/clock_div_gen.sv | 82 ++++++++
 tb/tb_clock_div_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_gen_pkg.sv
// Shared mode encodings and FSM state type for the divided-clock generator.
// Latency: n/a (types only). Backpressure: n/a.
// Imported by the top and by the per-channel divider.
package clock_div_gen_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: half-period counter, active divisor, clk/tick regs.
// Latency: clk_o/tick_o registered, update on the edge the half-period ends.
// Backpressure: none; freezes whenever adv_i is low.
module clk_div_chan #(
    parameter int DIV_W    = 16,
    parameter int DEF_HALF = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             adv_i,
    input  logic [DIV_W-1:0] half_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             rise_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] last_cnt;
    logic             wrap;

    // A divisor of 0 behaves as 1, i.e. the half-period ends at count 0.
    assign last_cnt = (act_q == '0) ? '0 : act_q - DIV_W'(1);
    // >= rather than == so a divisor shrunk while frozen cannot strand the counter.
    assign wrap     = adv_i && (cnt_q >= last_cnt);
    assign rise_o   = wrap && !clk_q;

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (!adv_i) begin
            act_d = half_i;
        end else if (wrap) begin
            cnt_d  = '0;
            clk_d  = !clk_q;
            act_d  = half_i;
            tick_d = !clk_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            act_q  <= DIV_W'(DEF_HALF);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clock_div_gen.sv
// Multi-channel clock divider with HALT/RUN/single-STEP control.
// Latency: outputs registered; mode changes take effect on the next edge.
// Backpressure: step_i ignored while busy_o or when mode is not STEP.
module clock_div_gen
    import clock_div_gen_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int DIV_W    = 16,
    parameter int DEF_HALF = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_CH*DIV_W-1:0] half_i,
    input  logic [1:0]            mode_i,
    input  logic                  step_i,
    output logic [N_CH-1:0]       clk_o,
    output logic [N_CH-1:0]       tick_o,
    output logic                  busy_o
);

    state_e          state_q;
    logic            busy_q;
    logic            adv;
    logic [N_CH-1:0] rise;
    logic            unused_rise;

    // Gating on mode_i as well as state makes a leave/abort freeze on the very next edge.
    assign adv = ((state_q == ST_RUN)  && (mode_i == MODE_RUN)) ||
                 ((state_q == ST_STEP) && (mode_i == MODE_STEP));

    // Only channel 0 paces a step; the other channels' rise flags are not needed.
    assign unused_rise = ^rise;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        clk_div_chan #(
            .DIV_W    (DIV_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .adv_i  (adv),
            .half_i (half_i[k*DIV_W +: DIV_W]),
            .clk_o  (clk_o[k]),
            .tick_o (tick_o[k]),
            .rise_o (rise[k])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mode_i == MODE_RUN) begin
                        state_q <= ST_RUN;
                    end else if ((mode_i == MODE_STEP) && step_i) begin
                        state_q <= ST_STEP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (mode_i != MODE_RUN) state_q <= ST_IDLE;
                end
                ST_STEP: begin
                    if ((mode_i != MODE_STEP) || rise[0]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_clock_div_gen.sv
// Bench for clock_div_gen: behavioural model compared every cycle plus
// hand-computed checkpoints for reset, RUN, divisor change, STEP, abort and half=0.
module tb_clock_div_gen;

    localparam int N_CH  = 2;
    localparam int DIV_W = 16;

    logic                  CLK   = 1'b0;
    logic                  RST_N = 1'b0;
    logic [N_CH*DIV_W-1:0] half_i;
    logic [1:0]            mode_i;
    logic                  step_i;
    logic [N_CH-1:0]       clk_o;
    logic [N_CH-1:0]       tick_o;
    logic                  busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    clock_div_gen #(.N_CH(N_CH), .DIV_W(DIV_W), .DEF_HALF(1)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .half_i (half_i),
        .mode_i (mode_i),
        .step_i (step_i),
        .clk_o  (clk_o),
        .tick_o (tick_o),
        .busy_o (busy_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each channel spends max(divisor,1) advancing cycles per level,
    // taking a new divisor at a level change or whenever frozen.
    int m_spent [N_CH];
    int m_div   [N_CH];
    bit m_lvl   [N_CH];
    bit m_tick  [N_CH];
    int m_mode_st;   // 0 idle, 1 running, 2 stepping

    always @(posedge CLK or negedge RST_N) begin
        bit moving;
        bit ch0_rose;
        int need;
        if (!RST_N) begin
            for (int k = 0; k < N_CH; k++) begin
                m_spent[k] = 0; m_div[k] = 1; m_lvl[k] = 0; m_tick[k] = 0;
            end
            m_mode_st = 0;
        end else begin
            moving   = (m_mode_st == 1 && mode_i == 2'd1) || (m_mode_st == 2 && mode_i == 2'd2);
            ch0_rose = 0;
            for (int k = 0; k < N_CH; k++) begin
                need = (m_div[k] == 0) ? 1 : m_div[k];
                m_tick[k] = 0;
                if (moving) begin
                    m_spent[k] = m_spent[k] + 1;
                    if (m_spent[k] >= need) begin
                        m_spent[k] = 0;
                        m_lvl[k]   = !m_lvl[k];
                        m_tick[k]  = m_lvl[k];
                        if (k == 0 && m_lvl[k]) ch0_rose = 1;
                        m_div[k] = int'(half_i[k*DIV_W +: DIV_W]);
                    end
                end else begin
                    m_div[k] = int'(half_i[k*DIV_W +: DIV_W]);
                end
            end
            case (m_mode_st)
                0: if (mode_i == 2'd1) m_mode_st = 1;
                   else if (mode_i == 2'd2 && step_i) m_mode_st = 2;
                1: if (mode_i != 2'd1) m_mode_st = 0;
                default: if (mode_i != 2'd2 || ch0_rose) m_mode_st = 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            for (int k = 0; k < N_CH; k++) begin
                check($sformatf("model_clk%0d", k), clk_o[k], m_lvl[k]);
                check($sformatf("model_tick%0d", k), tick_o[k], m_tick[k]);
            end
            check("model_busy", busy_o, m_mode_st == 2);
        end
    end

    task automatic do_reset(input logic [15:0] h0, input logic [15:0] h1);
        RST_N  = 1'b0;
        half_i = {h1, h0};
        mode_i = 2'b00;
        step_i = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic wait_tick0(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!tick_o[0] && n < 100);
        if (!tick_o[0]) check("tick0_wait_timeout", tick_o[0], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, c1, bc, tc;
        half_i = '0; mode_i = 2'b00; step_i = 1'b0;
        #1;
        check("reset_clk", clk_o, 0);
        check("reset_tick", tick_o, 0);
        check("reset_busy", busy_o, 0);

        // half=3: first rise on the 3rd advancing cycle, period 6
        do_reset(16'd3, 16'd3);
        mode_i = 2'b01;
        repeat (3) @(negedge CLK);
        check("h3_before_rise", clk_o[0], 0);
        @(negedge CLK);
        check("h3_first_rise", clk_o[0], 1);
        check("h3_first_tick", tick_o[0], 1);
        @(negedge CLK);
        check("h3_tick_one_cycle", tick_o[0], 0);
        wait_tick0(n);
        check("h3_period", n, 5);

        // ch0 half 2, ch1 half 5 over 40 cycles
        do_reset(16'd2, 16'd5);
        mode_i = 2'b01;
        c0 = 0; c1 = 0;
        repeat (40) begin
            @(negedge CLK);
            c0 += int'(tick_o[0]);
            c1 += int'(tick_o[1]);
        end
        check("two_ch_ticks0", c0, 10);
        check("two_ch_ticks1", c1, 4);

        // divisor change mid half-period does not shorten it
        do_reset(16'd4, 16'd4);
        mode_i = 2'b01;
        repeat (3) @(negedge CLK);
        half_i = {16'd1, 16'd1};
        wait_tick0(n);
        check("chg_finish_half4", n, 2);
        wait_tick0(n);
        check("chg_new_period2", n, 2);

        // park with clk_o[0]=1, then single step (fall then rise)
        do_reset(16'd2, 16'd2);
        mode_i = 2'b01;
        wait_tick0(n);
        check("park_rise_at", n, 3);
        mode_i = 2'b00;
        repeat (3) @(negedge CLK);
        check("park_clk_held", clk_o[0], 1);
        mode_i = 2'b10; step_i = 1'b1;
        bc = 0; tc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            bc += int'(busy_o);
            tc += int'(tick_o[0]);
            if (i == 0) step_i = 1'b0;
            if (i == 1) step_i = 1'b1;
            if (i == 2) step_i = 1'b0;
        end
        check("step_busy_cycles", bc, 4);
        check("step_tick_count", tc, 1);
        check("step_end_clk", clk_o[0], 1);
        check("step_end_busy", busy_o, 0);

        // abort a step by leaving STEP mode
        step_i = 1'b1;
        @(negedge CLK);
        step_i = 1'b0;
        check("abort_busy_on", busy_o, 1);
        @(negedge CLK);
        mode_i = 2'b00;
        @(negedge CLK);
        check("abort_busy_off", busy_o, 0);
        check("abort_clk_frozen", clk_o[0], 1);
        repeat (3) @(negedge CLK);
        check("abort_still_frozen", clk_o[0], 1);

        // asynchronous reset mid-run, then restart from count 0
        do_reset(16'd3, 16'd3);
        mode_i = 2'b01;
        wait_tick0(n);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_clk", clk_o, 0);
        check("async_rst_tick", tick_o, 0);
        check("async_rst_busy", busy_o, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_tick0(n);
        check("post_rst_first_rise", n, 4);

        // half=0 behaves as half=1
        do_reset(16'd0, 16'd0);
        mode_i = 2'b01;
        wait_tick0(n);
        check("h0_first_rise", n, 2);
        @(negedge CLK);
        check("h0_fall", clk_o[0], 0);
        check("h0_tick_low", tick_o[0], 0);
        @(negedge CLK);
        check("h0_rise", clk_o[0], 1);
        check("h0_tick_high", tick_o[0], 1);

        // mode 11 acts as HALT; RUN wins over a simultaneous step
        do_reset(16'd2, 16'd2);
        mode_i = 2'b11; step_i = 1'b1;
        repeat (3) @(negedge CLK);
        check("mode3_busy", busy_o, 0);
        check("mode3_clk", clk_o[0], 0);
        mode_i = 2'b01;
        @(negedge CLK);
        check("run_wins_busy", busy_o, 0);
        step_i = 1'b0;
        wait_tick0(n);
        check("run_wins_rise", n, 2);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
